// File: rtl/pipe_pkg.sv
// Shared pipeline constants and register-address helpers for the 5-stage MIPS core.
package pipe_pkg;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;
  localparam int unsigned REG_AW       = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // $0 is hardwired, so a match on it never represents a real dependency.
  function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
    return (a != REG_ZERO) && (a == b);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy tracker for the multi-cycle mult/div unit: loads on a start in E, counts down to idle.
module md_busy_counter
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic multStart,
  input  logic divStart,
  output logic mdBusy
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_nz;

  assign w_cnt_nz = (r_cnt != '0);

  // Starts are only honoured while idle; div wins if both are asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_cnt_nz) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (divStart) begin
      r_cnt <= CNT_W'(DIV_CYC);
    end else if (multStart) begin
      r_cnt <= CNT_W'(MULT_CYC);
    end
  end

  assign mdBusy = w_cnt_nz || multStart || divStart;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: load-use, branch-operand and mult/div-busy hazards ORed into one stall.
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic              useRs_D,
  input  logic              useRt_D,
  input  logic              branch_D,
  input  logic              md_D,
  input  logic              regWrite_E,
  input  logic              memToReg_E,
  input  logic [REG_AW-1:0] wAddr_E,
  input  logic              memToReg_M,
  input  logic [REG_AW-1:0] wAddr_M,
  input  logic              multStart_E,
  input  logic              divStart_E,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              mdBusy
);

  logic w_load_use;
  logic w_branch_haz;
  logic w_md_haz;
  logic w_stall;

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_busy (
    .clk       (clk),
    .reset     (reset),
    .multStart (multStart_E),
    .divStart  (divStart_E),
    .mdBusy    (mdBusy)
  );

  always_comb begin
    w_load_use   = memToReg_E &&
                   ((useRs_D && reg_match(rs_D, wAddr_E)) ||
                    (useRt_D && reg_match(rt_D, wAddr_E)));
    // Branches resolve in D, so both E results and M loads are too late to forward.
    w_branch_haz = branch_D &&
                   ((regWrite_E && (reg_match(rs_D, wAddr_E) || reg_match(rt_D, wAddr_E))) ||
                    (memToReg_M && (reg_match(rs_D, wAddr_M) || reg_match(rt_D, wAddr_M))));
    w_md_haz     = md_D && mdBusy;
    w_stall      = w_load_use || w_branch_haz || w_md_haz;
  end

  assign StallF = w_stall;
  assign StallD = w_stall;
  assign FlushE = w_stall;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed plan cases then random traffic vs. a cycle-count model.
module tb_hazard_stall_ctrl;

  localparam int MULT = 5;
  localparam int DIV  = 10;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       useRs;
    logic       useRt;
    logic       branch;
    logic       md;
    logic       regWrite;
    logic       memE;
    logic [4:0] wE;
    logic       memM;
    logic [4:0] wM;
    logic       mult;
    logic       div;
    logic       rst;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, wAddr_E, wAddr_M;
  logic       useRs_D, useRt_D, branch_D, md_D;
  logic       regWrite_E, memToReg_E, memToReg_M;
  logic       multStart_E, divStart_E;
  logic       StallF, StallD, FlushE, mdBusy;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_q[$];   // {stall, mdBusy}
  int         cyc      = 0;
  int         busy_end = -1;  // last cycle in which the unit is still counting

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .MULT_CYC (MULT),
    .DIV_CYC  (DIV),
    .CNT_W    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rs_D        (rs_D),
    .rt_D        (rt_D),
    .useRs_D     (useRs_D),
    .useRt_D     (useRt_D),
    .branch_D    (branch_D),
    .md_D        (md_D),
    .regWrite_E  (regWrite_E),
    .memToReg_E  (memToReg_E),
    .wAddr_E     (wAddr_E),
    .memToReg_M  (memToReg_M),
    .wAddr_M     (wAddr_M),
    .multStart_E (multStart_E),
    .divStart_E  (divStart_E),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushE      (FlushE),
    .mdBusy      (mdBusy)
  );

  function automatic bit same_reg(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  task automatic check(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp_v);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rs_D = s.rs; rt_D = s.rt; useRs_D = s.useRs; useRt_D = s.useRt;
    branch_D = s.branch; md_D = s.md; regWrite_E = s.regWrite;
    memToReg_E = s.memE; wAddr_E = s.wE; memToReg_M = s.memM; wAddr_M = s.wM;
    multStart_E = s.mult; divStart_E = s.div; reset = s.rst;
  endtask

  // One cycle: drive, predict from the hazard rules and the busy window, then advance the window.
  task automatic step(input stim_t s);
    bit lu, br, busy, md;
    @(posedge clk);
    #1;
    apply(s);
    lu   = s.memE && ((s.useRs && same_reg(s.rs, s.wE)) || (s.useRt && same_reg(s.rt, s.wE)));
    br   = s.branch && ((s.regWrite && (same_reg(s.rs, s.wE) || same_reg(s.rt, s.wE))) ||
                        (s.memM && (same_reg(s.rs, s.wM) || same_reg(s.rt, s.wM))));
    busy = (cyc <= busy_end) || s.mult || s.div;
    md   = s.md && busy;
    exp_q.push_back({lu || br || md, busy});
    if (s.rst) begin
      if (busy_end > cyc) busy_end = cyc;
    end else if (cyc > busy_end) begin
      if (s.div)       busy_end = cyc + DIV;
      else if (s.mult) busy_end = cyc + MULT;
    end
    cyc++;
  endtask

  initial begin : monitor
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("StallF", StallF, e[1]);
        check("StallD", StallD, e[1]);
        check("FlushE", FlushE, e[1]);
        check("mdBusy", mdBusy, e[0]);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    int    waitc;
    s = idle();
    s.rst = 1'b1;
    apply(s);
    @(posedge clk);
    #1;

    // Load-use, then cleared
    s = idle(); s.memE = 1; s.wE = 8; s.rs = 8; s.useRs = 1; step(s);
    s.memE = 0; step(s);
    // $0 immunity
    s = idle(); s.memE = 1; s.wE = 0; s.rs = 0; s.useRs = 1; step(s);
    s = idle(); s.branch = 1; s.regWrite = 1; s.wE = 0; step(s);
    // Branch hazards from E and from an M load
    s = idle(); s.branch = 1; s.rt = 9; s.regWrite = 1; s.wE = 9; step(s);
    s = idle(); s.branch = 1; s.rt = 9; s.memM = 1; s.wM = 9; step(s);
    s = idle(); s.branch = 1; s.rt = 9; step(s);
    // Mult busy with md_D held
    s = idle(); s.md = 1; s.mult = 1; step(s);
    s.mult = 0;
    for (int i = 0; i < 7; i++) step(s);
    // Div busy with an ignored mult at cycle 3
    s = idle(); s.div = 1; step(s);
    s.div = 0;
    for (int i = 1; i < 13; i++) begin
      s.mult = (i == 3);
      step(s);
    end
    // Both starts: div length wins
    s = idle(); s.mult = 1; s.div = 1; step(s);
    s = idle(); s.md = 1;
    for (int i = 0; i < 12; i++) step(s);
    // Reset mid-count
    s = idle(); s.div = 1; step(s);
    s = idle(); s.md = 1;
    for (int i = 1; i < 8; i++) begin
      s.rst = (i == 4);
      step(s);
    end

    // Random traffic on a small register window so matches are frequent
    for (int i = 0; i < 600; i++) begin
      s.rs = 5'($urandom_range(0, 3));
      s.rt = 5'($urandom_range(0, 3));
      s.wE = 5'($urandom_range(0, 3));
      s.wM = 5'($urandom_range(0, 3));
      s.useRs    = 1'($urandom_range(0, 1));
      s.useRt    = 1'($urandom_range(0, 1));
      s.branch   = ($urandom_range(0, 3) == 0);
      s.md       = 1'($urandom_range(0, 1));
      s.regWrite = 1'($urandom_range(0, 1));
      s.memE     = ($urandom_range(0, 2) == 0);
      s.memM     = ($urandom_range(0, 2) == 0);
      s.mult     = ($urandom_range(0, 9) == 0);
      s.div      = ($urandom_range(0, 14) == 0);
      s.rst      = ($urandom_range(0, 39) == 0);
      step(s);
    end

    s = idle(); step(s);
    waitc = 0;
    while (exp_q.size() > 0 && waitc < 20) begin
      @(posedge clk);
      waitc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline stall/flush controller for the 5-stage MIPS core.
- Produces the StallF that freezes the PC register, plus StallD (IF/ID hold) and FlushE (ID/EX bubble).
- Combines combinational load-use and branch-operand hazard detection with a sequential busy counter that models the multi-cycle mult/div unit.
- A HI/LO-using instruction in D stalls until the multiply/divide unit finishes.

Parameters:
- MULT_CYC, 5: busy cycles after mult/multu leaves E.
- DIV_CYC, 10: busy cycles after div/divu leaves E.
- CNT_W, 4: busy counter width; must hold DIV_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rs_D  in  5  rs field of instruction in D.
- rt_D  in  5  rt field of instruction in D.
- useRs_D  in  1  D instruction reads rs in E or later.
- useRt_D  in  1  D instruction reads rt in E or later.
- branch_D  in  1  D instruction is a branch/jr that compares or reads registers in D.
- md_D  in  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- regWrite_E  in  1  E instruction writes the register file.
- memToReg_E  in  1  E instruction is a load.
- wAddr_E  in  5  destination register of the E instruction.
- memToReg_M  in  1  M instruction is a load.
- wAddr_M  in  5  destination register of the M instruction.
- multStart_E  in  1  mult/multu is in E this cycle.
- divStart_E  in  1  div/divu is in E this cycle.
- StallF  out  1  hold PC (drives the PC enable inverse).
- StallD  out  1  hold the IF/ID register.
- FlushE  out  1  clear the ID/EX register (insert bubble).
- mdBusy  out  1  multiply/divide unit busy.

Behaviour:
- Register $0 never creates a hazard: any compare involving address 0 is false.
- loadUse = memToReg_E && ((useRs_D && rs_D==wAddr_E) || (useRt_D && rt_D==wAddr_E)).
- branchHaz = branch_D && (A || B):
  - A: regWrite_E && (rs_D==wAddr_E || rt_D==wAddr_E).
  - B: memToReg_M && (rs_D==wAddr_M || rt_D==wAddr_M).
- Busy counter cnt (CNT_W bits):
  - Reset: cnt=0.
  - Each clk with cnt==0: divStart_E loads DIV_CYC; else multStart_E loads MULT_CYC; else cnt holds 0.
  - If both starts are asserted (illegal), div wins.
  - cnt!=0: decrement by 1 per cycle. Start pulses are ignored while cnt!=0; this cannot occur legally because md_D is stalled.
  - mdBusy = (cnt!=0) || multStart_E || divStart_E. The start cycle counts as busy.
  - After a mult enters E at cycle T, mdBusy is high for cycles T..T+MULT_CYC and low at T+MULT_CYC+1.
- mdHaz = md_D && mdBusy.
- stall = loadUse || branchHaz || mdHaz.
- Outputs: StallF = StallD = FlushE = stall. All are combinational from current inputs and cnt. No added latency.
- Reset: cnt=0 at the edge where reset=1. While reset is high, the start inputs are ignored and the counter stays 0.
  - The outputs remain combinational during reset and reflect input hazards.
  - Reset mid-operation aborts any count. mdBusy is low the next cycle unless a start is present.
- Counter wrap-around is impossible: decrement happens only when cnt!=0, and loads are ≤ 2^CNT_W − 1. Static check: DIV_CYC < 2^CNT_W.
- Simultaneous hazards: outputs are an OR of all hazards; there is no priority.
- No combinational path from StallF to any input.

Decomposition:
- Shared package pipe_pkg:
  - Constants MULT_CYC_DEF=5 and DIV_CYC_DEF=10.
  - Register-address width 5.
  - Constant REG_ZERO=5'd0.
- One sub-module md_busy_counter: clk, reset, multStart, divStart → mdBusy.
  - Holds the counter and load/decrement logic.
  - Top level keeps the hazard comparators and the OR.

Test Plan:
- Load-use: memToReg_E=1, wAddr_E=8, rs_D=8, useRs_D=1 → StallF=StallD=FlushE=1 that cycle. Next cycle memToReg_E=0 → all 0.
- $0 immunity: memToReg_E=1, wAddr_E=0, rs_D=0, useRs_D=1 → stall=0. Repeat for branch_D with regWrite_E=1, wAddr_E=0 → stall=0.
- Branch hazard: branch_D=1, rt_D=9, regWrite_E=1, wAddr_E=9 → stall=1. Then memToReg_M=1, wAddr_M=9, E clear → stall=1. Both clear → 0.
- Mult busy:
  - multStart_E pulse at cycle 0, md_D=1 held → StallF=1 for cycles 0–5, 0 at cycle 6.
  - mdBusy sequence: 1,1,1,1,1,1,0.
- Div busy and collision:
  - divStart_E at cycle 0 → mdBusy high for cycles 0–10.
  - multStart_E pulse at cycle 3 → ignored; busy still ends at cycle 11.
  - multStart_E and divStart_E together → DIV_CYC loaded.
- Reset mid-count: divStart_E at cycle 0, reset=1 at cycle 4 → cnt=0 after that edge, mdBusy=0 at cycle 5 with md_D=1 → stall=0.
